// File: rtl/status_led.sv
// Status display for a memory self-test on the Fomu RGB LED: dark when idle, blue breathing
// while running, dim green on pass, dim blinking red on fail. Every output is registered.
module status_led #(
  parameter int unsigned CLK_FREQ = 48_000_000,
  parameter int unsigned BLINK_HZ = 2,
  parameter logic [7:0]  DUTY     = 8'h40
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_running,
  input  logic       i_passed,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b,
  output logic [1:0] o_state
);

  localparam int unsigned BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned STEP_DIV  = CLK_FREQ / 512;
  localparam int unsigned BlinkW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned StepW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);
  localparam logic [StepW-1:0]  StepMax  = StepW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StPass = 2'b10,
    StFail = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        pwm_q;
  logic [7:0]        level_q, level_d;
  logic              dir_down_q, dir_down_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic              phase_q, phase_d;
  logic              led_r_q, led_g_q, led_b_q;
  logic              led_r_d, led_g_d, led_b_d;
  logic              enter_run, enter_fail;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_running) state_d = StRun;
      StRun: begin
        if (!i_running) state_d = i_passed ? StPass : StFail;
      end
      StPass, StFail: if (i_running) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  assign enter_run  = (state_d == StRun) && (state_q != StRun);
  assign enter_fail = (state_d == StFail) && (state_q != StFail);

  // Triangle breathing: bounce off 255 and 0 without dwelling, so a full cycle is 510 steps.
  always_comb begin
    level_d    = level_q;
    dir_down_d = dir_down_q;
    step_d     = step_q;
    if (enter_run) begin
      level_d    = 8'd0;
      dir_down_d = 1'b0;
      step_d     = '0;
    end else if (state_q == StRun) begin
      if (step_q == StepMax) begin
        step_d = '0;
        if (!dir_down_q) begin
          if (level_q == 8'hff) begin
            dir_down_d = 1'b1;
            level_d    = 8'hfe;
          end else begin
            level_d = level_q + 8'd1;
          end
        end else begin
          if (level_q == 8'd0) begin
            dir_down_d = 1'b0;
            level_d    = 8'd1;
          end else begin
            level_d = level_q - 8'd1;
          end
        end
      end else begin
        step_d = step_q + StepW'(1);
      end
    end
  end

  // Phase starts high on entry so the failure is visible immediately.
  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    if (enter_fail) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (state_q == StFail) begin
      if (blink_q == BlinkMax) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BlinkW'(1);
      end
    end
  end

  always_comb begin
    led_b_d = (state_q == StRun) && (level_q > pwm_q);
    led_g_d = (state_q == StPass) && (DUTY > pwm_q);
    led_r_d = (state_q == StFail) && phase_q && (DUTY > pwm_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pwm_q      <= 8'd0;
      level_q    <= 8'd0;
      dir_down_q <= 1'b0;
      step_q     <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b0;
      led_r_q    <= 1'b0;
      led_g_q    <= 1'b0;
      led_b_q    <= 1'b0;
    end else begin
      pwm_q      <= pwm_q + 8'd1;
      level_q    <= level_d;
      dir_down_q <= dir_down_d;
      step_q     <= step_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      led_r_q    <= led_r_d;
      led_g_q    <= led_g_d;
      led_b_q    <= led_b_d;
    end
  end

  assign o_state = state_q;
  assign o_led_r = led_r_q;
  assign o_led_g = led_g_q;
  assign o_led_b = led_b_q;

endmodule

// File: tb/tb_status_led.sv
// Bench for status_led: a time-based reference model checked every cycle, plus directed
// literal checks on state sequencing, duty counts and blink windows, then random stimulus.
module tb_status_led;

  localparam int unsigned ClkFreq  = 2048;
  localparam int unsigned BlinkHz  = 2;
  localparam int          StepDiv  = 4;
  localparam int          BlinkDiv = 512;
  localparam int          DutyLvl  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       running = 1'b0;
  logic       passed = 1'b0;
  logic       led_r, led_g, led_b;
  logic [1:0] state;

  status_led #(
    .CLK_FREQ(ClkFreq),
    .BLINK_HZ(BlinkHz),
    .DUTY    (8'h40)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_running(running),
    .i_passed (passed),
    .o_led_r  (led_r),
    .o_led_g  (led_g),
    .o_led_b  (led_b),
    .o_state  (state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: state as an integer, everything else derived from edge counts since reset/entry.
  int   m_state = 0;
  int   m_cyc = 0;
  int   m_run_e = 0;
  int   m_fail_e = 0;
  logic m_r = 1'b0, m_g = 1'b0, m_b = 1'b0;

  function automatic int breath_level(input int d);
    int p;
    p = (d / StepDiv) % 510;
    return (p <= 255) ? p : 510 - p;
  endfunction

  function automatic bit blink_on(input int d);
    return ((d / BlinkDiv) % 2) == 0;
  endfunction

  function automatic int next_state(input int s, input bit r, input bit p);
    case (s)
      0:       return r ? 1 : 0;
      1:       return r ? 1 : (p ? 2 : 3);
      default: return r ? 1 : s;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state  <= 0;
      m_cyc    <= 0;
      m_run_e  <= 0;
      m_fail_e <= 0;
      m_r      <= 1'b0;
      m_g      <= 1'b0;
      m_b      <= 1'b0;
    end else begin
      m_b <= (m_state == 1) && (breath_level(m_cyc - m_run_e) > (m_cyc % 256));
      m_g <= (m_state == 2) && (DutyLvl > (m_cyc % 256));
      m_r <= (m_state == 3) && blink_on(m_cyc - m_fail_e) && (DutyLvl > (m_cyc % 256));
      m_state <= next_state(m_state, running, passed);
      if (next_state(m_state, running, passed) == 1 && m_state != 1) m_run_e <= m_cyc + 1;
      if (next_state(m_state, running, passed) == 3 && m_state != 3) m_fail_e <= m_cyc + 1;
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (state !== 2'(m_state) || led_r !== m_r || led_g !== m_g || led_b !== m_b) begin
        miscompares++;
        $display("FAIL model t=%0t: got state=%0d rgb=%b%b%b, want state=%0d rgb=%b%b%b",
                 $time, state, led_r, led_g, led_b, m_state, m_r, m_g, m_b);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic count_leds(input int n, input bit jitter, output int r, output int g,
                            output int b);
    r = 0;
    g = 0;
    b = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r += int'(led_r);
      g += int'(led_g);
      b += int'(led_b);
      if (jitter) passed = 1'($urandom_range(0, 1));
    end
  endtask

  int r1, g1, b1, r2, g2, b2, bad_state;

  initial begin
    // Reset asserted mid-cycle from an unknown power-up state.
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("reset_state", int'(state), 0);
    check("reset_leds", int'({led_r, led_g, led_b}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle for 2000 cycles.
    bad_state = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bad_state += int'(state != 2'b00);
    end
    check("idle_state", bad_state, 0);
    count_leds(1, 1'b0, r1, g1, b1);
    check("idle_leds", r1 + g1 + b1, 0);

    // Run, then pass.
    running = 1'b1;
    @(negedge clk);
    check("run_state", int'(state), 1);
    count_leds(256, 1'b0, r1, g1, b1);
    count_leds(256, 1'b0, r2, g2, b2);
    check("blue_rising", int'(b2 > b1), 1);
    check("run_other_leds", r1 + g1 + r2 + g2, 0);
    repeat (3000 - 513) @(negedge clk);
    running = 1'b0;
    passed = 1'b1;
    @(negedge clk);
    check("pass_state", int'(state), 2);
    @(negedge clk);
    count_leds(256, 1'b0, r1, g1, b1);
    check("pass_green_duty", g1, 64);
    check("pass_other_leds", r1 + b1, 0);

    // Re-run from PASS.
    running = 1'b1;
    @(negedge clk);
    check("rerun_state", int'(state), 1);
    @(negedge clk);
    check("rerun_green_off", int'(led_g), 0);
    count_leds(3, 1'b0, r1, g1, b1);
    check("rerun_level_zero", b1, 0);

    // Run, then fail, with i_passed jittering afterwards.
    repeat (300) @(negedge clk);
    running = 1'b0;
    passed = 1'b0;
    @(negedge clk);
    check("fail_state", int'(state), 3);
    count_leds(512, 1'b1, r1, g1, b1);
    count_leds(512, 1'b1, r2, g2, b2);
    check("fail_red_on_window", r1, 128);
    check("fail_red_off_window", r2, 0);
    check("fail_other_leds", g1 + b1 + g2 + b2, 0);
    check("fail_hold", int'(state), 3);

    // Reset mid-run with i_running held high.
    running = 1'b1;
    @(negedge clk);
    check("rerun2_state", int'(state), 1);
    repeat (400) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_leds", int'({led_r, led_g, led_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_run", int'(state), 1);
    count_leds(4, 1'b0, r1, g1, b1);
    check("post_rst_level_zero", r1 + g1 + b1, 0);

    // Single-cycle run pulse.
    #2 rst = 1'b1;
    running = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    passed = 1'b0;
    @(negedge clk);
    check("pulse_idle", int'(state), 0);
    running = 1'b1;
    @(negedge clk);
    check("pulse_run", int'(state), 1);
    running = 1'b0;
    @(negedge clk);
    check("pulse_fail", int'(state), 3);

    // Random segments, occasional async reset.
    for (int s = 0; s < 60; s++) begin
      running = 1'($urandom_range(0, 1));
      passed = 1'($urandom_range(0, 1));
      for (int c = $urandom_range(1, 400); c > 0; c--) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) passed = ~passed;
      end
      if ($urandom_range(0, 9) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
